// File: rtl/id_ex_stage.sv
// RV32I decode stage: decode, immediate generation, operand bypass, hazard stall and the ID/EX register.
// Build option: define RV_ID_FORWARD_EN for EX/MEM/WB bypassing; otherwise any in-flight RAW hazard stalls.
module id_ex_stage #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_pc,
    input  logic [31:0]     id_idata,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rf_rv1,
    input  logic [XLEN-1:0] rf_rv2,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [31:0]     ex_pc,
    output logic [31:0]     ex_idata,
    output logic [XLEN-1:0] ex_rv1,
    output logic [XLEN-1:0] ex_rv2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             use_rs1;
    logic             use_rs2;
    logic             writes_rd;
    logic             is_load;
    logic [31:0]      imm;

    assign opcode   = id_idata[6:0];
    assign rs1      = id_idata[19:15];
    assign rs2      = id_idata[24:20];
    assign rd       = id_idata[11:7];
    assign rs1_addr = rs1;
    assign rs2_addr = rs2;

    // Source usage, writeback class and immediate format per opcode
    always_comb begin : decode
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        imm       = '0;
        case (opcode)
            OP_REG: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{id_idata[31]}}, id_idata[31:25], id_idata[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{19{id_idata[31]}}, id_idata[31], id_idata[7],
                           id_idata[30:25], id_idata[11:8], 1'b0};
            end
            OP_IMM, OP_JALR: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                imm       = {{20{id_idata[31]}}, id_idata[31:20]};
            end
            OP_LOAD: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
                imm       = {{20{id_idata[31]}}, id_idata[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                imm       = {id_idata[31:12], 12'h000};
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                imm       = {{11{id_idata[31]}}, id_idata[31], id_idata[19:12],
                             id_idata[20], id_idata[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Source matches against each in-flight writer; x0 never matches
    logic ex_writes;
    logic rs1_ex;
    logic rs2_ex;
    logic rs1_mem;
    logic rs2_mem;
    logic hazard;

    assign ex_writes = ex_valid & ex_regwrite;
    assign rs1_ex    = use_rs1 && (rs1 != '0) && ex_writes && (ex_rd == rs1);
    assign rs2_ex    = use_rs2 && (rs2 != '0) && ex_writes && (ex_rd == rs2);
    assign rs1_mem   = use_rs1 && (rs1 != '0) && mem_regwrite && (mem_rd == rs1);
    assign rs2_mem   = use_rs2 && (rs2 != '0) && mem_regwrite && (mem_rd == rs2);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

`ifdef RV_ID_FORWARD_EN
    logic rs1_wb;
    logic rs2_wb;
    logic ex_fwd_ok;

    assign rs1_wb    = use_rs1 && (rs1 != '0) && wb_regwrite && (wb_rd == rs1);
    assign rs2_wb    = use_rs2 && (rs2 != '0) && wb_regwrite && (wb_rd == rs2);
    assign ex_fwd_ok = ~ex_memread;
    assign hazard    = ex_memread & (rs1_ex | rs2_ex);

    // Youngest producer wins: EX, then MEM, then WB, then the regfile
    always_comb begin : bypass
        op1 = rf_rv1;
        op2 = rf_rv2;
        if (use_rs1) begin
            if (rs1 == '0)                op1 = '0;
            else if (rs1_ex && ex_fwd_ok) op1 = ex_alu_result;
            else if (rs1_mem)             op1 = mem_result;
            else if (rs1_wb)              op1 = wb_result;
        end
        if (use_rs2) begin
            if (rs2 == '0)                op2 = '0;
            else if (rs2_ex && ex_fwd_ok) op2 = ex_alu_result;
            else if (rs2_mem)             op2 = mem_result;
            else if (rs2_wb)              op2 = wb_result;
        end
    end
`else
    // No bypass: wait until the producer reaches WB, where the write-first regfile supplies it
    logic unused_bypass;

    assign unused_bypass = ^{ex_alu_result, mem_result, wb_rd, wb_regwrite, wb_result};
    assign hazard        = rs1_ex | rs2_ex | rs1_mem | rs2_mem;
    assign op1           = rf_rv1;
    assign op2           = rf_rv2;
`endif

    logic bubble;

    assign stall  = id_valid & ~flush & hazard;
    assign bubble = flush | stall | ~id_valid;

    // ID/EX pipeline register; reset and bubble load the same NOP state
    always_ff @(posedge clk) begin : id_ex_reg
        if (rst || bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_idata    <= NOP_INSTR;
            ex_rv1      <= '0;
            ex_rv2      <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_idata    <= id_idata;
            ex_rv1      <= op1;
            ex_rv2      <= op2;
            ex_imm      <= XLEN'(imm);
            ex_rd       <= writes_rd ? rd : '0;
            ex_regwrite <= writes_rd & (rd != '0);
            ex_memread  <= is_load;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction vectors, expectations queued, monitor compares ID/EX.
module tb_id_ex_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI1  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] ADDI2  = 32'h0030_8113; // addi x2,x1,3
    localparam logic [31:0] ADDI8  = 32'h0010_0413; // addi x8,x0,1
    localparam logic [31:0] ADD9   = 32'h0084_04B3; // add x9,x8,x8
    localparam logic [31:0] ADD10  = 32'h0084_0533; // add x10,x8,x8
    localparam logic [31:0] LW5    = 32'h0000_2283; // lw x5,0(x0)
    localparam logic [31:0] ADD6   = 32'h0052_8333; // add x6,x5,x5
    localparam logic [31:0] SRAI   = 32'h4042_5193; // srai x3,x4,4
    localparam logic [31:0] SW     = 32'hFE20_AE23; // sw x2,-4(x1)
    localparam logic [31:0] BEQ    = 32'hFE00_0CE3; // beq x0,x0,-8
    localparam logic [31:0] LUI    = 32'h1234_53B7; // lui x7,0x12345
    localparam logic [31:0] JAL    = 32'h0010_00EF; // jal x1,+0x800
    localparam logic [31:0] BADOP  = 32'hFFFF_FFFF;
    localparam logic [31:0] AUIPC  = 32'hFFFF_F297; // auipc x5,0xFFFFF
    localparam logic [31:0] JALR   = 32'hFF01_80E7; // jalr x1,-16(x3)
    localparam logic [31:0] ADDI12 = 32'h0070_0613; // addi x12,x0,7
    localparam logic [31:0] ADD13  = 32'h0000_06B3; // add x13,x0,x0

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] idata;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_idata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rf_rv1;
    logic [31:0] rf_rv2;
    logic [31:0] ex_alu_result;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_idata;
    logic [31:0] ex_rv1;
    logic [31:0] ex_rv2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;

    logic [31:0] rf [32];
    exp_t        q [$];
    int          checks   = 0;
    int          failures = 0;

    assign rf_rv1 = rf[rs1_addr];
    assign rf_rv2 = rf[rs2_addr];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_idata      (id_idata),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rf_rv1        (rf_rv1),
        .rf_rv2        (rf_rv2),
        .ex_alu_result (ex_alu_result),
        .mem_rd        (mem_rd),
        .mem_regwrite  (mem_regwrite),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_result     (wb_result),
        .flush         (flush),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_idata      (ex_idata),
        .ex_rv1        (ex_rv1),
        .ex_rv2        (ex_rv2),
        .ex_imm        (ex_imm),
        .ex_rd         (ex_rd),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] idata,
                                input logic [31:0] rv1, input logic [31:0] rv2,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic rw, input logic mr);
        exp_t e;
        e.v = 1'b1; e.pc = pc; e.idata = idata; e.rv1 = rv1; e.rv2 = rv2;
        e.imm = imm; e.rd = rd; e.rw = rw; e.mr = mr;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = '0;
        e.idata = NOP;
        return e;
    endfunction

    // Monitor: one ID/EX snapshot per cycle against the oldest queued expectation
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            a = {ex_valid, ex_pc, ex_idata, ex_rv1, ex_rv2, ex_imm, ex_rd, ex_regwrite, ex_memread};
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL idex: act v=%0b pc=%h id=%h rv1=%h rv2=%h imm=%h rd=%0d rw=%0b mr=%0b | exp v=%0b pc=%h id=%h rv1=%h rv2=%h imm=%h rd=%0d rw=%0b mr=%0b",
                             a.v, a.pc, a.idata, a.rv1, a.rv2, a.imm, a.rd, a.rw, a.mr,
                             e.v, e.pc, e.idata, e.rv1, e.rv2, e.imm, e.rd, e.rw, e.mr);
                end
            end else if (ex_valid) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: act ex_valid=1 pc=%h exp no output", ex_pc);
            end
        end
    end

    task automatic cyc(input string name, input logic exp_stall, input exp_t e);
        #1;
        checks++;
        if (stall !== exp_stall) begin
            failures++;
            $display("FAIL stall[%s]: act=%0b exp=%0b", name, stall, exp_stall);
        end
        if (id_valid) begin
            checks++;
            if (rs1_addr !== id_idata[19:15] || rs2_addr !== id_idata[24:20]) begin
                failures++;
                $display("FAIL rs_addr[%s]: act=%0d/%0d exp=%0d/%0d", name, rs1_addr, rs2_addr,
                         id_idata[19:15], id_idata[24:20]);
            end
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        id_valid = 1'b0; id_pc = '0; id_idata = NOP; flush = 1'b0;
        ex_alu_result = '0;
        mem_rd = '0; mem_regwrite = 1'b0; mem_result = '0;
        wb_rd = '0; wb_regwrite = 1'b0; wb_result = '0;
    endtask

    task automatic idle();
        clr();
        cyc("idle", 1'b0, bub());
    endtask

    task automatic issue(input string name, input logic [31:0] pc, input logic [31:0] idata,
                         input logic exp_stall, input exp_t e);
        id_valid = 1'b1; id_pc = pc; id_idata = idata;
        cyc(name, exp_stall, e);
    endtask

    initial begin : driver
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
        clr();
        rst = 1'b1;
        cyc("rst0", 1'b0, bub());
        cyc("rst1", 1'b0, bub());
        rst = 1'b0;

        // Back-to-back RAW through EX
        issue("addi1", 32'h100, ADDI1, 1'b0, mk(32'h100, ADDI1, 32'h0, 32'h1005, 32'h5, 5'd1, 1'b1, 1'b0));
        ex_alu_result = 32'd5;
`ifdef RV_ID_FORWARD_EN
        issue("addi2", 32'h104, ADDI2, 1'b0, mk(32'h104, ADDI2, 32'h5, 32'h1003, 32'h3, 5'd2, 1'b1, 1'b0));
`else
        issue("addi2_ex", 32'h104, ADDI2, 1'b1, bub());
        ex_alu_result = '0; mem_rd = 5'd1; mem_regwrite = 1'b1; mem_result = 32'd5;
        issue("addi2_mem", 32'h104, ADDI2, 1'b1, bub());
        mem_regwrite = 1'b0; mem_rd = '0; wb_rd = 5'd1; wb_regwrite = 1'b1; wb_result = 32'd5;
        rf[1] = 32'd5;
        issue("addi2_wb", 32'h104, ADDI2, 1'b0, mk(32'h104, ADDI2, 32'h5, 32'h1003, 32'h3, 5'd2, 1'b1, 1'b0));
        rf[1] = 32'h1001;
`endif
        idle(); idle();

        // Bypass priority EX > MEM > WB on x8
        issue("addi8", 32'h110, ADDI8, 1'b0, mk(32'h110, ADDI8, 32'h0, 32'h1001, 32'h1, 5'd8, 1'b1, 1'b0));
        ex_alu_result = 32'hE0;
        mem_rd = 5'd8; mem_regwrite = 1'b1; mem_result = 32'h3E0;
        wb_rd = 5'd8; wb_regwrite = 1'b1; wb_result = 32'h4B0;
`ifdef RV_ID_FORWARD_EN
        issue("p_ex", 32'h114, ADD9, 1'b0, mk(32'h114, ADD9, 32'hE0, 32'hE0, 32'h0, 5'd9, 1'b1, 1'b0));
        ex_alu_result = 32'h77;
        issue("p_mem", 32'h118, ADD10, 1'b0, mk(32'h118, ADD10, 32'h3E0, 32'h3E0, 32'h0, 5'd10, 1'b1, 1'b0));
        mem_rd = 5'd9; mem_result = 32'h77;
        issue("p_wb", 32'h11C, ADD10, 1'b0, mk(32'h11C, ADD10, 32'h4B0, 32'h4B0, 32'h0, 5'd10, 1'b1, 1'b0));
`else
        issue("p_ex", 32'h114, ADD9, 1'b1, bub());
        ex_alu_result = '0;
        issue("p_mem", 32'h114, ADD9, 1'b1, bub());
        mem_regwrite = 1'b0;
        issue("p_wb", 32'h114, ADD9, 1'b0, mk(32'h114, ADD9, 32'h1008, 32'h1008, 32'h0, 5'd9, 1'b1, 1'b0));
`endif
        idle(); idle();

        // Load-use: one stall, then the load value from MEM
        issue("lw", 32'h200, LW5, 1'b0, mk(32'h200, LW5, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1));
        issue("lu_stall", 32'h204, ADD6, 1'b1, bub());
        mem_rd = 5'd5; mem_regwrite = 1'b1; mem_result = 32'h1234_5678;
`ifdef RV_ID_FORWARD_EN
        issue("lu_fwd", 32'h204, ADD6, 1'b0, mk(32'h204, ADD6, 32'h1234_5678, 32'h1234_5678, 32'h0, 5'd6, 1'b1, 1'b0));
`else
        issue("lu_mem", 32'h204, ADD6, 1'b1, bub());
        mem_regwrite = 1'b0; mem_rd = '0;
        wb_rd = 5'd5; wb_regwrite = 1'b1; wb_result = 32'h1234_5678;
        rf[5] = 32'h1234_5678;
        issue("lu_wb", 32'h204, ADD6, 1'b0, mk(32'h204, ADD6, 32'h1234_5678, 32'h1234_5678, 32'h0, 5'd6, 1'b1, 1'b0));
        rf[5] = 32'h1005;
`endif
        idle(); idle();

        // Immediate formats and writeback classes
        issue("srai", 32'h300, SRAI, 1'b0, mk(32'h300, SRAI, 32'h1004, 32'h1004, 32'h404, 5'd3, 1'b1, 1'b0));
        issue("sw", 32'h304, SW, 1'b0, mk(32'h304, SW, 32'h1001, 32'h1002, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0));
        issue("beq", 32'h308, BEQ, 1'b0, mk(32'h308, BEQ, 32'h0, 32'h0, 32'hFFFF_FFF8, 5'd0, 1'b0, 1'b0));
        issue("lui", 32'h30C, LUI, 1'b0, mk(32'h30C, LUI, 32'h1008, 32'h1003, 32'h1234_5000, 5'd7, 1'b1, 1'b0));
        issue("jal", 32'h310, JAL, 1'b0, mk(32'h310, JAL, 32'h0, 32'h1001, 32'h800, 5'd1, 1'b1, 1'b0));
        issue("badop", 32'h314, BADOP, 1'b0, mk(32'h314, BADOP, 32'h101F, 32'h101F, 32'h0, 5'd0, 1'b0, 1'b0));
        issue("auipc", 32'h318, AUIPC, 1'b0, mk(32'h318, AUIPC, 32'h101F, 32'h101F, 32'hFFFF_F000, 5'd5, 1'b1, 1'b0));
        issue("jalr", 32'h31C, JALR, 1'b0, mk(32'h31C, JALR, 32'h1003, 32'h1010, 32'hFFFF_FFF0, 5'd1, 1'b1, 1'b0));
        idle(); idle();

        // Flush beats a concurrent load-use stall, and kills a plain instruction
        issue("lw2", 32'h400, LW5, 1'b0, mk(32'h400, LW5, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1));
        flush = 1'b1;
        issue("flush_lu", 32'h404, ADD6, 1'b0, bub());
        issue("flush_only", 32'h408, ADDI1, 1'b0, bub());
        idle();

        // Writes to x0 in MEM/WB must not reach x0 consumers
        mem_rd = 5'd0; mem_regwrite = 1'b1; mem_result = 32'hDEAD;
        wb_rd = 5'd0; wb_regwrite = 1'b1; wb_result = 32'hDEAD;
        issue("x0_imm", 32'h500, ADDI12, 1'b0, mk(32'h500, ADDI12, 32'h0, 32'h1007, 32'h7, 5'd12, 1'b1, 1'b0));
        issue("x0_reg", 32'h504, ADD13, 1'b0, mk(32'h504, ADD13, 32'h0, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0));
        idle();

        // Reset in the middle of a load-use stall
        issue("lw3", 32'h600, LW5, 1'b0, mk(32'h600, LW5, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1));
        rst = 1'b1;
        issue("rst_stall", 32'h604, ADD6, 1'b1, bub());
        rst = 1'b0;
        issue("post_rst", 32'h604, ADD6, 1'b0, mk(32'h604, ADD6, 32'h1005, 32'h1005, 32'h0, 5'd6, 1'b1, 1'b0));
        idle(); idle();

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: act pending=%0d exp 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
